// File: rtl/ofm_write_ctrl.sv
// OFM write controller: round-robin serialisation of per-lane output bytes
// into the single OFM write port, with per-lane row counters and a
// start/busy/done frame around each layer pass.

// Per-lane row counter; row == DEPTH marks the lane as full for this pass.
module ofm_lane_ctr #(
    parameter int DEPTH = 44,
    parameter int ROW_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ROW_W-1:0] row,
    output logic             full,
    output logic             last
);

    assign full = (row == ROW_W'(DEPTH));
    assign last = (row == ROW_W'(DEPTH - 1));

    // Row count: cleared at pass start, bumped on each accepted transfer.
    // The grant is already masked by full, so the count cannot pass DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      row <= '0;
        else if (clr) row <= '0;
        else if (inc) row <= row + 1'b1;
    end

endmodule

module ofm_write_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 44,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         address,
    output logic [DATA_W-1:0]         wrData,
    output logic                      wren,
    output logic [NUM_REQ-1:0]        lane_full,
    output logic                      busy,
    output logic                      done
);

    localparam int ROW_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state, state_nxt;
    logic                            clr;
    logic [PTR_W-1:0]                rr_ptr;
    logic [PTR_W-1:0]                gnt_idx;
    logic [PTR_W-1:0]                idx;
    logic                            gnt_found;
    logic [NUM_REQ-1:0]              gnt_oh;
    logic [NUM_REQ-1:0]              elig;
    logic [NUM_REQ-1:0]              last;
    logic [NUM_REQ-1:0]              full_after;
    logic [NUM_REQ-1:0][ROW_W-1:0]   row;
    logic [ADDR_W-1:0]               addr_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            ofm_lane_ctr #(.DEPTH(DEPTH), .ROW_W(ROW_W)) u_ctr (
                .clk  (clk),
                .rst  (rst),
                .clr  (clr),
                .inc  (gnt_oh[gi]),
                .row  (row[gi]),
                .full (lane_full[gi]),
                .last (last[gi])
            );
        end
    endgenerate

    assign elig       = (state == RUN) ? (req_valid & ~lane_full) : '0;
    assign req_ready  = gnt_oh;
    assign full_after = lane_full | (gnt_oh & last);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign addr_nxt   = ADDR_W'(row[gnt_idx]) * ADDR_W'(NUM_REQ) + ADDR_W'(gnt_idx);

    // Round-robin search from rr_ptr upward, wrapping; first eligible lane wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
        if (gnt_found) gnt_oh[gnt_idx] = 1'b1;
    end

    // Pass framing: start opens a pass from IDLE/DONE; the transfer that
    // fills the last lane closes it.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        case (state)
            IDLE: if (start) begin
                clr       = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (gnt_found && (&full_after)) state_nxt = DONE;
            DONE: if (start) begin
                clr       = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (clr)            rr_ptr <= '0;
            else if (gnt_found) rr_ptr <= PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
        end
    end

    // Registered OFM write port; address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wren    <= 1'b0;
            address <= '0;
            wrData  <= '0;
        end else begin
            wren <= gnt_found;
            if (gnt_found) begin
                address <= addr_nxt;
                wrData  <= req_data[gnt_idx*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_ofm_write_ctrl.sv
// Self-checking bench for ofm_write_ctrl: tasks predict grants and push the
// expected OFM writes into a queue; a monitor pops and compares each write.
module tb_ofm_write_ctrl;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 44;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      start = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         address;
    logic [DATA_W-1:0]         wrData;
    logic                      wren;
    logic [NUM_REQ-1:0]        lane_full;
    logic                      busy;
    logic                      done;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    ofm_write_ctrl #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .address   (address),
        .wrData    (wrData),
        .wren      (wren),
        .lane_full (lane_full),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every OFM write must match the oldest expected entry.
    always @(negedge clk) begin
        if (wren === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%0d, required no write", address, wrData);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (address !== e.addr || wrData !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write: addr=%0d data=%0d cyc=%0d, required addr=%0d data=%0d cyc=%0d",
                             address, wrData, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input int a, input int d);
        exp_t e;
        e.addr = ADDR_W'(a);
        e.data = DATA_W'(d);
        e.cyc  = cyc + 1;
        q.push_back(e);
    endtask

    task automatic chk_ready(input string name, input logic [NUM_REQ-1:0] exp);
        checks++;
        if (req_ready !== exp) begin
            errors++;
            $display("FAIL %s: req_ready=%b, required %b", name, req_ready, exp);
        end
    endtask

    task automatic chk_status(input string name, input logic b, input logic d,
                              input logic [NUM_REQ-1:0] lf);
        checks++;
        if (busy !== b || done !== d || lane_full !== lf) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b lane_full=%b, required busy=%b done=%b lane_full=%b",
                     name, busy, done, lane_full, b, d, lf);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
    endtask

    // Leaves the bench at posedge+1 of the first RUN cycle.
    task automatic start_pass();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '1;
        #2;
        checks++;
        if (wren !== 1'b0 || address !== '0 || wrData !== '0) begin
            errors++;
            $display("FAIL reset_port: wren=%b addr=%0d data=%0d, required 0 0 0", wren, address, wrData);
        end
        chk_ready("reset_ready", '0);
        chk_status("reset_status", 1'b0, 1'b0, '0);
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_ready("idle_ready", '0);
            chk_status("idle_status", 1'b0, 1'b0, '0);
        end
        req_valid = '0;
    endtask

    task automatic test_single_lane();
        do_reset();
        start_pass();
        req_valid = 4'b0100;
        for (int r = 0; r < DEPTH; r++) begin
            req_data = '0;
            req_data[2*DATA_W +: DATA_W] = DATA_W'(r);
            @(negedge clk);
            chk_ready("single_ready", 4'b0100);
            push_exp(r*NUM_REQ + 2, r);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk_ready("single_full_ready", '0);
        chk_status("single_after", 1'b1, 1'b0, 4'b0100);
        start_pass();
        @(negedge clk);
        chk_status("start_in_run", 1'b1, 1'b0, 4'b0100);
        chk_ready("start_in_run_ready", '0);
        repeat (3) @(posedge clk);
        #1 req_valid = '0;
    endtask

    task automatic drive_all(input int n);
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'(i*50 + n);
    endtask

    task automatic test_all_lanes();
        do_reset();
        start_pass();
        for (int n = 0; n < DEPTH*NUM_REQ; n++) begin
            drive_all(n);
            @(negedge clk);
            chk_ready("all_ready", NUM_REQ'(1) << (n % NUM_REQ));
            push_exp(n, (n % NUM_REQ)*50 + n);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (wren !== 1'b1) begin
            errors++;
            $display("FAIL final_wren: wren=%b, required 1", wren);
        end
        chk_status("all_done", 1'b0, 1'b1, 4'b1111);
        chk_ready("done_ready", '0);
        // Restart from DONE: flags clear and addressing begins at 0.
        start_pass();
        for (int n = 0; n < NUM_REQ; n++) begin
            for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'(200 + i + n);
            @(negedge clk);
            if (n == 0) chk_status("restart_status", 1'b1, 1'b0, '0);
            chk_ready("restart_ready", NUM_REQ'(1) << n);
            push_exp(n, 200 + n + n);
            @(posedge clk); #1;
        end
        req_valid = '0;
    endtask

    task automatic test_fairness();
        do_reset();
        start_pass();
        req_valid = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            req_data = '0;
            req_data[0 +: DATA_W]        = DATA_W'(k);
            req_data[3*DATA_W +: DATA_W] = DATA_W'(100 + k);
            @(negedge clk);
            if (k % 2 == 0) begin
                chk_ready("fair_ready0", 4'b0001);
                push_exp(4*(k/2), k);
            end else begin
                chk_ready("fair_ready3", 4'b1000);
                push_exp(4*(k/2) + 3, 100 + k);
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_midpass();
        do_reset();
        start_pass();
        for (int n = 0; n < 10; n++) begin
            drive_all(n);
            @(negedge clk);
            chk_ready("mid_ready", NUM_REQ'(1) << (n % NUM_REQ));
            push_exp(n, (n % NUM_REQ)*50 + n);
            @(posedge clk); #1;
        end
        checks++;
        if (wren !== 1'b1) begin
            errors++;
            $display("FAIL mid_wren_before: wren=%b, required 1", wren);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (wren !== 1'b0 || address !== '0 || wrData !== '0) begin
            errors++;
            $display("FAIL mid_reset_port: wren=%b addr=%0d data=%0d, required 0 0 0", wren, address, wrData);
        end
        chk_status("mid_reset_status", 1'b0, 1'b0, '0);
        chk_ready("mid_reset_ready", '0);
        q.delete();
        @(posedge clk); #1; rst = 1'b0;
        start_pass();
        for (int n = 0; n < 2; n++) begin
            drive_all(n);
            @(negedge clk);
            chk_ready("post_reset_ready", NUM_REQ'(1) << n);
            push_exp(n, n*50 + n);
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_all_lanes();
        test_fairness();
        test_reset_midpass();
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: pending=%0d, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
